bcd_gray_scheduler: RTL and testbench

//  Round-robin scheduler that time-shares one combinational BCD-to-Gray converter among NREQ requesters.
//  It picks a winner, drives the shared converter's b3..b0 inputs, and captures its d3..d0 outputs.
//  It then returns a tagged, registered result with an invalid-BCD flag.

---
 rtl/bcd_gray_scheduler_pkg.sv | 15 +
 rtl/bcd_gray_scheduler_if.sv | 31 +++
 rtl/bcd_gray_scheduler_rr_pick.sv | 27 ++
 rtl/bcd_gray_scheduler.sv | 112 +++++++++++
 tb/tb_bcd_gray_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_gray_scheduler_pkg.sv
// Shared types and constants for the BCD-to-Gray round-robin scheduler.
package bcd_gray_scheduler_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_gray_scheduler_if.sv
// Requester, converter and result signals of the scheduler.
interface bcd_gray_scheduler_if #(
  parameter int NREQ = 4,
  parameter int ERRW = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] bcd_in;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        conv_b;
  logic [3:0]        conv_d;
  logic              out_valid;
  logic [3:0]        out_gray;
  logic [IDW-1:0]    out_id;
  logic              out_err;
  logic              busy;
  logic [ERRW-1:0]   err_cnt;

  modport master (
    output req, bcd_in, conv_d,
    input  gnt, conv_b, out_valid, out_gray,
    input  out_id, out_err, busy, err_cnt
  );

  modport slave (
    input  req, bcd_in, conv_d,
    output gnt, conv_b, out_valid, out_gray,
    output out_id, out_err, busy, err_cnt
  );
endinterface

// File: rtl/bcd_gray_scheduler_rr_pick.sv
// Combinational rotating-priority pick: first set req at or above ptr.
module bcd_gray_scheduler_rr_pick #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_any,
  output logic [IDW-1:0]  o_idx,
  output logic [NREQ-1:0] o_onehot
);

  int j;

  // Walk downward so the candidate closest to ptr is assigned last.
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (i_req[j]) o_idx = IDW'(j);
    end
    o_onehot = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/bcd_gray_scheduler.sv
// Time-shares one external BCD-to-Gray converter among NREQ requesters.
module bcd_gray_scheduler
  import bcd_gray_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ERRW = 8
) (
  input logic               clk,
  input logic               rst,
  bcd_gray_scheduler_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_wid;
  logic [NREQ-1:0] r_gnt;
  logic [3:0]      r_conv_b;
  logic            r_out_valid;
  logic [3:0]      r_out_gray;
  logic [IDW-1:0]  r_out_id;
  logic            r_out_err;
  logic [ERRW-1:0] r_err_cnt;

  logic            w_any;
  logic [IDW-1:0]  w_idx;
  logic [NREQ-1:0] w_onehot;
  logic [3:0]      w_digit;
  logic [IDW-1:0]  w_ptr_nxt;

  bcd_gray_scheduler_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  always_comb begin
    w_digit = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == IDW'(i)) w_digit = bus.bcd_in[4*i +: 4];
    end
  end

  assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0
                                               : w_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_state_nxt = S_CONV;
      S_CONV: w_state_nxt = S_IDLE;
    endcase
  end

  // conv_d is sampled in S_CONV, a full cycle after conv_b settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_wid       <= '0;
      r_gnt       <= '0;
      r_conv_b    <= '0;
      r_out_valid <= 1'b0;
      r_out_gray  <= '0;
      r_out_id    <= '0;
      r_out_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= '0;
      r_out_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt    <= w_onehot;
            r_conv_b <= w_digit;
            r_wid    <= w_idx;
            r_ptr    <= w_ptr_nxt;
          end
        end
        S_CONV: begin
          r_out_valid <= 1'b1;
          r_out_id    <= r_wid;
          if (is_bcd(r_conv_b)) begin
            r_out_gray <= bus.conv_d;
            r_out_err  <= 1'b0;
          end else begin
            r_out_gray <= '0;
            r_out_err  <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.conv_b    = r_conv_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_gray  = r_out_gray;
  assign bus.out_id    = r_out_id;
  assign bus.out_err   = r_out_err;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_bcd_gray_scheduler.sv
// Directed self-checking bench for bcd_gray_scheduler with a converter model.
module tb_bcd_gray_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  bcd_gray_scheduler_if #(.NREQ(4), .ERRW(8)) bus ();

  bcd_gray_scheduler #(.NREQ(4), .ERRW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.conv_d = {bus.conv_b[3],
                       bus.conv_b[3] | bus.conv_b[2],
                       bus.conv_b[2] ^ bus.conv_b[1],
                       bus.conv_b[1] ^ bus.conv_b[0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.bcd_in = 16'h9876;
    tick();
    tick();
    n_total++;
    if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.gnt);
    else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else n_pass++;
    n_total++;
    if (bus.err_cnt !== 8'd0) $display("FAIL reset_errcnt: got %0d want 0", bus.err_cnt);
    else n_pass++;
    n_total++;
    if ({bus.conv_b, bus.out_gray, bus.out_id, bus.out_err} !== 11'd0)
      $display("FAIL reset_regs: got %h want 0", {bus.conv_b, bus.out_gray, bus.out_id, bus.out_err});
    else n_pass++;
    rst = 1'b0;
    bus.req = '0;
  endtask

  task automatic test_single();
    bus.bcd_in = 16'h0000;
    bus.bcd_in[11:8] = 4'd5;
    bus.req = 4'b0100;
    tick();
    n_total++;
    if (bus.gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", bus.gnt);
    else n_pass++;
    n_total++;
    if (bus.conv_b !== 4'b0101) $display("FAIL single_convb: got %b want 0101", bus.conv_b);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL single_busy: got busy=%b valid=%b want 1/0", bus.busy, bus.out_valid);
    else n_pass++;
    bus.req = '0;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_gray !== 4'b0111 || bus.out_id !== 2'd2 || bus.out_err !== 1'b0)
      $display("FAIL single_result: got v=%b g=%b id=%0d e=%b want 1/0111/2/0",
               bus.out_valid, bus.out_gray, bus.out_id, bus.out_err);
    else n_pass++;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.out_gray !== 4'b0111 || bus.gnt !== 4'b0000)
      $display("FAIL single_hold: got v=%b g=%b gnt=%b want 0/0111/0000",
               bus.out_valid, bus.out_gray, bus.gnt);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0000, 4'b0010, 4'b1100, 4'b1101};
    do_reset();
    bus.bcd_in = {4'd9, 4'd8, 4'd3, 4'd0};
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++;
      if (bus.gnt !== (4'b0001 << k)) $display("FAIL cont_gnt%0d: got %b want %b", k, bus.gnt, 4'b0001 << k);
      else n_pass++;
      bus.req[k] = 1'b0;
      tick();
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== 2'(k) || bus.out_gray !== exp_g[k])
        $display("FAIL cont_res%0d: got v=%b id=%0d g=%b want 1/%0d/%b",
                 k, bus.out_valid, bus.out_id, bus.out_gray, k, exp_g[k]);
      else n_pass++;
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_id;
    bus.bcd_in = {4'd7, 4'd0, 4'd0, 4'd1};
    bus.req = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      exp_id = (k % 2 == 0) ? 2'd0 : 2'd3;
      tick();
      tick();
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id ||
          bus.out_gray !== ((exp_id == 2'd0) ? 4'b0001 : 4'b0100))
        $display("FAIL fair_%0d: got v=%b id=%0d g=%b want 1/%0d", k, bus.out_valid,
                 bus.out_id, bus.out_gray, exp_id);
      else n_pass++;
    end
    bus.req = '0;
  endtask

  task automatic test_invalid();
    bus.bcd_in = 16'h0000;
    bus.bcd_in[7:4] = 4'd12;
    bus.req = 4'b0010;
    tick();
    n_total++;
    if (bus.gnt !== 4'b0010 || bus.conv_b !== 4'd12)
      $display("FAIL inv_gnt: got gnt=%b b=%0d want 0010/12", bus.gnt, bus.conv_b);
    else n_pass++;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_gray !== 4'b0000 ||
        bus.out_id !== 2'd1 || bus.err_cnt !== 8'd1)
      $display("FAIL inv_res: got v=%b e=%b g=%b id=%0d cnt=%0d want 1/1/0000/1/1",
               bus.out_valid, bus.out_err, bus.out_gray, bus.out_id, bus.err_cnt);
    else n_pass++;
    for (int k = 0; k < 254; k++) begin
      tick();
      tick();
    end
    n_total++;
    if (bus.err_cnt !== 8'd255) $display("FAIL inv_cnt255: got %0d want 255", bus.err_cnt);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (bus.err_cnt !== 8'd255 || bus.out_valid !== 1'b1 || bus.out_err !== 1'b1)
      $display("FAIL inv_sat: got cnt=%0d v=%b e=%b want 255/1/1",
               bus.err_cnt, bus.out_valid, bus.out_err);
    else n_pass++;
    bus.req = '0;
  endtask

  task automatic test_sweep_abort();
    logic [3:0] exp;
    for (int d = 0; d < 10; d++) begin
      bus.bcd_in = 16'h0000;
      bus.bcd_in[3:0] = 4'(d);
      bus.req = 4'b0001;
      tick();
      bus.req = '0;
      tick();
      exp = 4'(d) ^ (4'(d) >> 1);
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.out_gray !== exp || bus.out_err !== 1'b0)
        $display("FAIL sweep_%0d: got v=%b g=%b e=%b want 1/%b/0",
                 d, bus.out_valid, bus.out_gray, bus.out_err, exp);
      else n_pass++;
    end
    bus.bcd_in = 16'h0000;
    bus.bcd_in[11:8] = 4'd12;
    bus.req = 4'b0100;
    tick();
    n_total++;
    if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1)
      $display("FAIL abort_gnt: got gnt=%b busy=%b want 0100/1", bus.gnt, bus.busy);
    else n_pass++;
    bus.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.err_cnt !== 8'd0 || bus.out_gray !== 4'd0)
      $display("FAIL abort_drop: got v=%b busy=%b cnt=%0d g=%b want 0/0/0/0000",
               bus.out_valid, bus.busy, bus.err_cnt, bus.out_gray);
    else n_pass++;
    bus.bcd_in = {4'd9, 4'd8, 4'd3, 4'd4};
    bus.req = 4'b1111;
    tick();
    n_total++;
    if (bus.gnt !== 4'b0001) $display("FAIL abort_next: got %b want 0001", bus.gnt);
    else n_pass++;
    bus.req = '0;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_gray !== 4'b0110)
      $display("FAIL abort_res: got v=%b id=%0d g=%b want 1/0/0110",
               bus.out_valid, bus.out_id, bus.out_gray);
    else n_pass++;
  endtask

  initial begin
    bus.req = '0;
    bus.bcd_in = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_invalid();
    test_sweep_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
